fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the fetch PC register and the IF/ID pipeline register. Issues requests to a variable-latency instruction memory and advances the PC to the `npc` value produced by the next-PC logic. Delivers `IR_D`/`PC_D` to decode, and raises a wait signal that the hazard unit uses to freeze the rest of the pipeline.

## Interface
- `PC_RESET`, default 32'h0000_3000, is the fetch address after reset.
- `clk` in, 1 bit: rising-edge clock.
- `reset` in, 1 bit: asynchronous reset, active high.
- `npc` in, 32 bits: next fetch address from the next-PC logic. It is computed from `PC_F`, `PC_D` and `IR_D`.
- `stall` in, 1 bit: hazard-unit stall. It freezes the F and D stages.
- `imem_ready` in, 1 bit: instruction memory has `imem_rdata` valid for the current request.
- `imem_rdata` in, 32 bits: instruction word.
- `imem_req` out, 1 bit: fetch request.
- `imem_addr` out, 32 bits: request address, always equal to `PC_F`.
- `PC_F` out, 32 bits: current fetch PC.
- `IR_D` out, 32 bits: instruction in decode.
- `PC_D` out, 32 bits: PC of `IR_D`.
- `valid_D` out, 1 bit: `IR_D` holds a real fetched instruction.
- `fetch_wait` out, 1 bit: fetch is waiting on memory. The hazard unit ORs it into the global freeze.

## Operation
- The state machine has two states.
  - FETCH: a request is outstanding, `imem_req`=1.
  - HOLD: an instruction is captured in the 32-bit skid register `ir_buf` while `stall`=1, `imem_req`=0.
- FETCH, `imem_ready`=1, `stall`=0:
  - `IR_D`←`imem_rdata`, `PC_D`←`PC_F`, `valid_D`←1, `PC_F`←`npc`.
  - Remain in FETCH.
- FETCH, `imem_ready`=1, `stall`=1:
  - `ir_buf`←`imem_rdata`, go to HOLD.
  - `PC_F`, `IR_D`, `PC_D`, `valid_D` are unchanged.
- FETCH, `imem_ready`=0:
  - All registers hold. `fetch_wait`=1, regardless of `stall`.
  - D is not bubbled; it holds so that a branch or jump in D keeps `npc` stable for its delay-slot fetch.
- HOLD, `stall`=1: all registers hold.
- HOLD, `stall`=0:
  - `IR_D`←`ir_buf`, `PC_D`←`PC_F`, `valid_D`←1, `PC_F`←`npc`.
  - Go to FETCH.
- `fetch_wait` = (state==FETCH) & ~`imem_ready`. It is combinational and is never asserted in HOLD.
- `imem_addr` = `PC_F`. `PC_F` changes only on the accept edges above, so the address is held stable for the whole request.
- `PC_F` is a full 32-bit register. `npc` is loaded unmodified; no alignment checking is done.
- Wrap-around at 32'hFFFF_FFFC is the `npc` logic's concern, not this block's.

## Timing
- Reset values, applied asynchronously:
  - `PC_F`=`PC_RESET`, `IR_D`=0 (nop), `PC_D`=0, `valid_D`=0, `ir_buf`=0.
  - State=FETCH.
  - Consequently `imem_req`=1 and `imem_addr`=`PC_RESET` during and immediately after reset.
- Zero-wait memory (`imem_ready` high in the request cycle) gives one instruction per cycle. `IR_D` is valid the edge after the address is presented.
- N-cycle memory: `fetch_wait` is high for N cycles, and the instruction reaches D on the edge where `imem_ready`=1.
- `imem_ready` is sampled only when `imem_req`=1; it is ignored in HOLD.
- Reset asserted mid-request abandons the request. The memory must tolerate an abandoned request and treat the next `imem_req` as new.
- Reset has priority over every other input.
- `stall` and `imem_ready` rising together: HOLD is entered. The memory is not re-requested for the same word.
- `stall` falling while in HOLD: the transfer occurs on that edge and the new request starts the following cycle with `PC_F`=`npc`.

## Test plan
- **Reset.** Assert `reset` mid-cycle, release, zero-wait memory returning 32'h2408_0001 at 0x3000 and `npc`=`PC_F`+4.
  - During reset: outputs are 0 and `PC_F`=0x3000 immediately.
  - Next edge: `IR_D`=32'h2408_0001, `PC_D`=0x3000, `PC_F`=0x3004.
- **Wait states.** `imem_ready` held low 3 cycles at `PC_F`=0x3004.
  - `fetch_wait`=1 for 3 cycles; `imem_addr` stays 0x3004; `IR_D`/`PC_D` unchanged.
  - On the ready edge: `PC_D`=0x3004.
- **Stall with zero-wait memory.** `stall`=1 for 2 cycles while fetching 0x3008 with data 32'hAABB_CCDD.
  - State=HOLD; `imem_req`=0; `PC_F` stays 0x3008.
  - On the edge where `stall`=0: `IR_D`=32'hAABB_CCDD, `PC_D`=0x3008, then `PC_F`=`npc`.
- **Branch redirect.** D holds a beq at 0x3010 (taken) with `npc`=0x3040, delay slot fetched at 0x3014 with a 2-cycle memory wait.
  - `PC_F` goes 0x3014 → 0x3040 only on the delay-slot accept edge.
  - `PC_D`=0x3014 for that delay-slot instruction.
- **Reset during wait.** `reset` asserted while `fetch_wait`=1 at 0x3020.
  - `PC_F`=0x3000 immediately; `valid_D`=0; state=FETCH.
  - A late `imem_ready` pulse during reset has no effect.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// a variable-latency instruction memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  // Fetch side issues requests and consumes returned words.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  // Memory side answers requests.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, IF/ID pipeline register and a one-word
// skid buffer that holds a returned instruction while decode is stalled.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         npc,
  input  logic                stall,
  fetch_unit_if.master        imem,
  output logic [31:0]         PC_F,
  output logic [31:0]         IR_D,
  output logic [31:0]         PC_D,
  output logic                valid_D,
  output logic                fetch_wait
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] ir_q,    ir_d;
  logic [31:0] pcd_q,   pcd_d;
  logic        vld_q,   vld_d;
  logic [31:0] buf_q,   buf_d;

  // Register update; reset abandons any outstanding request and restarts at PC_RESET.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= 32'h0000_0000;
      pcd_q   <= 32'h0000_0000;
      vld_q   <= 1'b0;
      buf_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pcd_q   <= pcd_d;
      vld_q   <= vld_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state: accept into decode when free, park in ir_buf when stalled.
  // A missing memory response holds everything, D included, so a branch in
  // decode keeps npc stable until its delay slot arrives.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pcd_d   = pcd_q;
    vld_d   = vld_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem.imem_ready) begin
          if (stall) begin
            buf_d   = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            ir_d  = imem.imem_rdata;
            pcd_d = pc_q;
            vld_d = 1'b1;
            pc_d  = npc;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          ir_d    = buf_q;
          pcd_d   = pc_q;
          vld_d   = 1'b1;
          pc_d    = npc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Request is outstanding exactly while in FETCH; address tracks the fetch PC.
  always_comb begin
    imem.imem_req  = (state_q == S_FETCH);
    imem.imem_addr = pc_q;
    fetch_wait     = (state_q == S_FETCH) && !imem.imem_ready;
  end

  assign PC_F    = pc_q;
  assign IR_D    = ir_q;
  assign PC_D    = pcd_q;
  assign valid_D = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios followed by
// randomized memory latency, stalls and redirects against a transaction model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic [31:0] PC_F, IR_D, PC_D;
  logic        valid_D, fetch_wait;

  fetch_unit_if imem();

  fetch_unit #(.PC_RESET(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .stall      (stall),
    .imem       (imem),
    .PC_F       (PC_F),
    .IR_D       (IR_D),
    .PC_D       (PC_D),
    .valid_D    (valid_D),
    .fetch_wait (fetch_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: the fetch PC, whether memory has already answered for
  // it (and with what word), and the instruction currently sitting in decode.
  logic [31:0] m_pc, m_word, m_ir, m_pcd;
  logic        m_answered, m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0000_3000;
    m_word     = 32'h0;
    m_ir       = 32'h0;
    m_pcd      = 32'h0;
    m_vld      = 1'b0;
    m_answered = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".PC_F"},    PC_F,           m_pc);
    chk({tag, ".IR_D"},    IR_D,           m_ir);
    chk({tag, ".PC_D"},    PC_D,           m_pcd);
    chk({tag, ".valid_D"}, {31'b0, valid_D}, {31'b0, m_vld});
  endtask

  // One clock: drive inputs, check the combinational request side, take the
  // edge, advance the model, check the registered outputs.
  task automatic step(input logic s, input logic r, input logic [31:0] n, input logic [31:0] w);
    stall           = s;
    imem.imem_ready = r;
    npc             = n;
    imem.imem_rdata = w;
    #1;
    chk("req",  {31'b0, imem.imem_req}, {31'b0, !m_answered});
    chk("addr", imem.imem_addr,         m_pc);
    chk("wait", {31'b0, fetch_wait},    {31'b0, (!m_answered && !r)});
    @(posedge clk);
    // Memory answers only an outstanding request; the word reaches decode
    // as soon as decode is not stalled, and fetch then moves to npc.
    if (!m_answered && r) begin
      m_answered = 1'b1;
      m_word     = w;
    end
    if (m_answered && !s) begin
      m_ir       = m_word;
      m_pcd      = m_pc;
      m_vld      = 1'b1;
      m_pc       = n;
      m_answered = 1'b0;
    end
    #1;
    check_regs("step");
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0E};
  endfunction

  initial begin
    logic        rs, rr;
    logic [31:0] rn, rw;

    reset           = 1'b0;
    stall           = 1'b0;
    npc             = 32'h0;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;
    model_reset();

    // Reset asserted mid-cycle takes effect immediately.
    #2 reset = 1'b1;
    #1;
    chk("rst.PC_F",  PC_F, 32'h0000_3000);
    chk("rst.IR_D",  IR_D, 32'h0);
    chk("rst.PC_D",  PC_D, 32'h0);
    chk("rst.valid", {31'b0, valid_D}, 32'h0);
    chk("rst.req",   {31'b0, imem.imem_req}, 32'h1);
    chk("rst.addr",  imem.imem_addr, 32'h0000_3000);
    // A ready response during reset is ignored.
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("rst.hold.PC_F", PC_F, 32'h0000_3000);
    chk("rst.hold.IR_D", IR_D, 32'h0);
    reset = 1'b0;

    // Zero-wait fetch of the first word.
    step(1'b0, 1'b1, m_pc + 32'd4, 32'h2408_0001);
    chk("tp1.IR_D", IR_D, 32'h2408_0001);
    chk("tp1.PC_D", PC_D, 32'h0000_3000);
    chk("tp1.PC_F", PC_F, 32'h0000_3004);

    // Three wait states at 0x3004.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, m_pc + 32'd4, 32'h0BAD_0000);
      chk("tp2.addr", imem.imem_addr, 32'h0000_3004);
      chk("tp2.PC_D", PC_D, 32'h0000_3000);
    end
    step(1'b0, 1'b1, m_pc + 32'd4, mem_word(m_pc));
    chk("tp2.ready.PC_D", PC_D, 32'h0000_3004);

    // Stall for two cycles with zero-wait memory at 0x3008.
    step(1'b1, 1'b1, m_pc + 32'd4, 32'hAABB_CCDD);
    chk("tp3.PC_F", PC_F, 32'h0000_3008);
    step(1'b1, 1'b1, m_pc + 32'd4, 32'h1234_5678);
    chk("tp3.req", {31'b0, imem.imem_req}, 32'h0);
    step(1'b0, 1'b0, m_pc + 32'd4, 32'h8765_4321);
    chk("tp3.IR_D", IR_D, 32'hAABB_CCDD);
    chk("tp3.PC_D", PC_D, 32'h0000_3008);
    chk("tp3.PC_F", PC_F, 32'h0000_300C);

    // Taken branch at 0x3010, delay slot at 0x3014 with two wait states.
    step(1'b0, 1'b1, m_pc + 32'd4, mem_word(m_pc));
    step(1'b0, 1'b1, m_pc + 32'd4, 32'h1109_000B);
    chk("tp4.br.PC_D", PC_D, 32'h0000_3010);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0000_3040, 32'h0);
      chk("tp4.wait.PC_F", PC_F, 32'h0000_3014);
    end
    step(1'b0, 1'b1, 32'h0000_3040, 32'h0000_0000);
    chk("tp4.PC_F", PC_F, 32'h0000_3040);
    chk("tp4.PC_D", PC_D, 32'h0000_3014);

    // Randomized latency, stalls and redirects.
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(2) == 0);
      rr = ($urandom_range(1) == 0);
      rn = ($urandom_range(3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : m_pc + 32'd4;
      rw = m_answered ? $urandom() : mem_word(m_pc);
      step(rs, rr, rn, rw);
    end

    // Drain any parked word, then steer fetch to 0x3020 and let it wait.
    step(1'b0, 1'b0, 32'h0000_3020, $urandom());
    if (m_pc != 32'h0000_3020)
      step(1'b0, 1'b1, 32'h0000_3020, mem_word(m_pc));
    step(1'b0, 1'b0, 32'h0000_3024, 32'h0);
    chk("tp5.wait", {31'b0, fetch_wait}, 32'h1);
    chk("tp5.PC_F", PC_F, 32'h0000_3020);

    // Reset during the wait, with a late ready pulse while reset is high.
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("tp5.rst.PC_F",  PC_F, 32'h0000_3000);
    chk("tp5.rst.valid", {31'b0, valid_D}, 32'h0);
    chk("tp5.rst.req",   {31'b0, imem.imem_req}, 32'h1);
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    imem.imem_ready = 1'b0;
    check_regs("tp5.rst.pulse");
    reset = 1'b0;

    // Fetch resumes cleanly from PC_RESET.
    step(1'b0, 1'b1, m_pc + 32'd4, mem_word(m_pc));
    chk("tp5.resume.PC_D", PC_D, 32'h0000_3000);
    step(1'b0, 1'b1, m_pc + 32'd4, mem_word(m_pc));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
